// File: rtl/data_selector_gather_pkg.sv
// -----------------------------------------------------------------------------
// data_selector_gather_pkg
// Shared definitions for the gathering data selector. It holds the per-lane
// origin encoding and the state encoding of the output FSM.
// -----------------------------------------------------------------------------
package data_selector_gather_pkg;

  // Per-lane origin field. These are the two LSBs of each lane selection.
  localparam logic [1:0] ORIG_MAIN = 2'b00;  // element of wData
  localparam logic [1:0] ORIG_REGS = 2'b01;  // element of wRegs
  localparam logic [1:0] ORIG_ZERO = 2'b10;  // constant zero
  localparam logic [1:0] ORIG_HOLD = 2'b11;  // this lane's previous value

  typedef enum logic {
    ST_IDLE = 1'b0,  // waiting for a transaction
    ST_EMIT = 1'b1   // streaming lane_buf out beat by beat
  } state_e;

  // Index width that stays at least one bit wide when there is a single element.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_selector_gather_lane.sv
// -----------------------------------------------------------------------------
// data_selector_lane
// Combinational resolution of one output lane from its selection field.
// Ports:
//   i_sel    lane selection {regs_idx, main_idx, origin[1:0]}
//   i_data   flat main word, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_regs   flat register file, packed the same way
//   i_prev   this lane's value from the previous accepted transaction
//   o_value  resolved lane value (0 when the used index is out of range)
//   o_err    the index used by this lane is out of range
// -----------------------------------------------------------------------------
module data_selector_lane
  import data_selector_gather_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int MAIN_INPUTS = 16,
  parameter int REGS_INPUTS = 64,
  parameter int MAIN_IDX_W  = idx_width(MAIN_INPUTS),
  parameter int REGS_IDX_W  = idx_width(REGS_INPUTS),
  parameter int SEL_W       = 2 + MAIN_IDX_W + REGS_IDX_W
) (
  input  logic [SEL_W-1:0]                   i_sel,
  input  logic [MAIN_INPUTS*DATA_WIDTH-1:0]  i_data,
  input  logic [REGS_INPUTS*DATA_WIDTH-1:0]  i_regs,
  input  logic [DATA_WIDTH-1:0]              i_prev,
  output logic [DATA_WIDTH-1:0]              o_value,
  output logic                               o_err
);

  logic [1:0]            w_origin;
  logic [MAIN_IDX_W-1:0] w_main_idx;
  logic [REGS_IDX_W-1:0] w_regs_idx;
  logic [DATA_WIDTH-1:0] w_main_val;
  logic [DATA_WIDTH-1:0] w_regs_val;
  logic                  w_main_hit;
  logic                  w_regs_hit;

  assign w_origin   = i_sel[1:0];
  assign w_main_idx = i_sel[2 +: MAIN_IDX_W];
  assign w_regs_idx = i_sel[2+MAIN_IDX_W +: REGS_IDX_W];

  // An index is in range exactly when one loop iteration matches it. That
  // avoids indexing past the end of the bus when the element count is not a
  // power of two.
  // NOTE: every signal written in an always_comb gets a default first; a path
  // that skips the assignment would otherwise infer a latch.
  always_comb begin
    w_main_val = '0;
    w_main_hit = 1'b0;
    for (int i = 0; i < MAIN_INPUTS; i++) begin
      if (w_main_idx == MAIN_IDX_W'(i)) begin
        w_main_val = i_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_main_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_regs_val = '0;
    w_regs_hit = 1'b0;
    for (int j = 0; j < REGS_INPUTS; j++) begin
      if (w_regs_idx == REGS_IDX_W'(j)) begin
        w_regs_val = i_regs[j*DATA_WIDTH +: DATA_WIDTH];
        w_regs_hit = 1'b1;
      end
    end
  end

  // Only the index field that the origin actually uses can raise an error.
  always_comb begin
    o_value = '0;
    o_err   = 1'b0;
    case (w_origin)
      ORIG_MAIN: begin
        o_value = w_main_val;
        o_err   = !w_main_hit;
      end
      ORIG_REGS: begin
        o_value = w_regs_val;
        o_err   = !w_regs_hit;
      end
      ORIG_ZERO: o_value = '0;
      ORIG_HOLD: o_value = i_prev;
      default:   o_value = '0;
    endcase
  end

endmodule

// File: rtl/data_selector_gather.sv
// -----------------------------------------------------------------------------
// data_selector_gather
// This block captures a main word, a register-file bus and per-lane selections
// in one handshake. It resolves all lanes into a registered lane buffer, then
// streams the buffer out as BEATS beats of OUT_LANES lanes under valid/ready.
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid / in_ready  transaction handshake (wData, wRegs, wSelec sampled)
//   wData                main word, MAIN_INPUTS elements
//   wRegs                register file, REGS_INPUTS elements
//   wSelec               LANES selection fields {regs_idx, main_idx, origin}
//   data_out             current beat, lowest lane of the beat in the LSBs
//   out_valid/out_ready  beat handshake
//   out_last             final beat of the transaction
//   sel_err              sticky out-of-range selection flag
// -----------------------------------------------------------------------------
module data_selector_gather
  import data_selector_gather_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int MAIN_INPUTS = 16,
  parameter int REGS_INPUTS = 64,
  parameter int LANES       = 16,   // must be a multiple of OUT_LANES
  parameter int OUT_LANES   = 4,
  localparam int MAIN_IDX_W = idx_width(MAIN_INPUTS),
  localparam int REGS_IDX_W = idx_width(REGS_INPUTS),
  localparam int SEL_W      = 2 + MAIN_IDX_W + REGS_IDX_W,
  localparam int BEATS      = LANES / OUT_LANES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MAIN_INPUTS*DATA_WIDTH-1:0] wData,
  input  logic [REGS_INPUTS*DATA_WIDTH-1:0] wRegs,
  input  logic [LANES*SEL_W-1:0]            wSelec,
  output logic [OUT_LANES*DATA_WIDTH-1:0]   data_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              sel_err
);

  localparam int BEAT_W    = idx_width(BEATS);
  localparam int BEAT_BITS = OUT_LANES * DATA_WIDTH;

  state_e                        r_state;
  state_e                        w_state_next;
  logic [BEAT_W-1:0]             r_beat;
  logic [LANES*DATA_WIDTH-1:0]   r_lane_buf;
  logic                          r_sel_err;

  logic [LANES*DATA_WIDTH-1:0]   w_lane_val;
  logic [LANES-1:0]              w_lane_err;
  logic                          w_in_ready;
  logic                          w_last;
  logic                          w_accept;
  logic                          w_beat_adv;

  // One resolver per lane. The hold source is the buffer before the accepting
  // edge, so back-to-back accepts see the previous transaction.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    data_selector_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MAIN_INPUTS (MAIN_INPUTS),
      .REGS_INPUTS (REGS_INPUTS),
      .MAIN_IDX_W  (MAIN_IDX_W),
      .REGS_IDX_W  (REGS_IDX_W),
      .SEL_W       (SEL_W)
    ) u_lane (
      .i_sel   (wSelec[k*SEL_W +: SEL_W]),
      .i_data  (wData),
      .i_regs  (wRegs),
      .i_prev  (r_lane_buf[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_value (w_lane_val[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_err   (w_lane_err[k])
    );
  end

  assign w_last     = (r_state == ST_EMIT) && (r_beat == BEAT_W'(BEATS - 1));
  assign w_accept   = in_valid && w_in_ready;
  assign w_beat_adv = (r_state == ST_EMIT) && out_ready && !w_last;

  // In EMIT a new transaction is taken only together with the final beat.
  // The buffer reloads on that edge without a bubble cycle.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_next = ST_EMIT;
      end
      ST_EMIT: begin
        w_in_ready = out_ready && w_last;
        if (out_ready && w_last && !in_valid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes hold read the old buffer.
  // NOTE: lane_buf is reset as well, because a hold lane after reset must
  // read 0 and not an undefined value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_lane_buf <= '0;
      r_sel_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_lane_buf <= w_lane_val;
        r_beat     <= '0;
        r_sel_err  <= r_sel_err | (|w_lane_err);
      end else if (w_beat_adv) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  // Output slice mux. A compare per beat avoids a multiplied part-select base.
  always_comb begin
    data_out = '0;
    if (r_state == ST_EMIT) begin
      for (int b = 0; b < BEATS; b++) begin
        if (r_beat == BEAT_W'(b)) data_out = r_lane_buf[b*BEAT_BITS +: BEAT_BITS];
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_EMIT);
  assign out_last  = w_last;
  assign sel_err   = r_sel_err;

endmodule
